// File: rtl/fdivsqrt_iter_ctrl.sv
// Iteration sequencer for the radix-4 divide/square-root datapath: accepts one op,
// counts radix-4 steps, handles special-case bypass, early exit, stall and flush.
module fdivsqrt_iter_ctrl #(
    parameter bit Q_SUPPORTED = 1'b0,
    parameter int CNTW        = 6
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            Start,
    input  logic            SqrtIn,
    input  logic [1:0]      Fmt,
    input  logic            SpecialCase,
    input  logic            WZero,
    input  logic            Stall,
    input  logic            Flush,
    output logic            Init,
    output logic            IterEn,
    output logic            j1,
    output logic            SqrtL,
    output logic            Busy,
    output logic            Done,
    output logic [CNTW-1:0] IterCnt
);

    // state | meaning
    // IDLE  | waiting for Start; Init combinational on Start & ~Flush
    // BUSY  | one radix-4 step per cycle, IterCnt counts down to 0
    // DONE  | result valid, held while Stall
    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_BUSY = 2'b01,
        S_DONE = 2'b10
    } state_t;

    state_t            state, state_nx;
    logic [CNTW-1:0]   cnt, cnt_nx;
    logic              sqrt_l, sqrt_nx;
    logic              first, first_nx;
    logic              accept;
    logic              j1_int;

    // Fmt only seeds the counter, so its effect is captured entirely in cnt.
    function automatic logic [CNTW-1:0] iter_last(input logic [1:0] f);
        logic [CNTW-1:0] r;
        case (f)
            2'b10:   r = CNTW'(6);
            2'b00:   r = CNTW'(13);
            2'b01:   r = CNTW'(27);
            default: r = Q_SUPPORTED ? CNTW'(57) : CNTW'(27);
        endcase
        return r;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= S_IDLE;
            cnt    <= '0;
            sqrt_l <= 1'b0;
            first  <= 1'b0;
        end else begin
            state  <= state_nx;
            cnt    <= cnt_nx;
            sqrt_l <= sqrt_nx;
            first  <= first_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        sqrt_nx  = sqrt_l;
        first_nx = first;
        Init     = 1'b0;
        IterEn   = 1'b0;
        j1_int   = 1'b0;
        Busy     = 1'b0;
        Done     = 1'b0;
        accept   = 1'b0;

        case (state)
            S_IDLE: begin
                // Gated by reset so Init stays low while reset is held.
                accept = Start & ~Flush & ~reset;
                Init   = accept;
                if (accept) begin
                    sqrt_nx = SqrtIn;
                    if (SpecialCase) begin
                        state_nx = S_DONE;
                    end else begin
                        cnt_nx   = iter_last(Fmt);
                        first_nx = 1'b1;
                        state_nx = S_BUSY;
                    end
                end
            end
            S_BUSY: begin
                Busy     = 1'b1;
                IterEn   = 1'b1;
                j1_int   = sqrt_l & first;
                first_nx = 1'b0;
                if (cnt == '0) begin
                    state_nx = S_DONE;
                end else begin
                    cnt_nx = cnt - CNTW'(1);
                end
                // The first sqrt step runs on a fixed selection row, so a zero
                // residual there is not yet meaningful.
                if (WZero && !j1_int) begin
                    state_nx = S_DONE;
                end
            end
            S_DONE: begin
                Done = 1'b1;
                if (!Stall) begin
                    state_nx = S_IDLE;
                end
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase

        if (Flush) begin
            state_nx = S_IDLE;
            cnt_nx   = '0;
            first_nx = 1'b0;
        end
    end

    assign j1      = j1_int;
    assign SqrtL   = sqrt_l;
    assign IterCnt = cnt;

    j1_only_sqrt: assert property (@(posedge clk) disable iff (reset) j1 |-> SqrtL);
    j1_single:    assert property (@(posedge clk) disable iff (reset) j1 |=> !j1);
    busy_done_x:  assert property (@(posedge clk) disable iff (reset) !(Busy && Done));

endmodule

// File: tb/tb_fdivsqrt_iter_ctrl.sv
// Self-checking bench for fdivsqrt_iter_ctrl: table-driven ops with a scoreboard
// queue, plus hand sequences for stall, early exit, flush and async reset.
module tb_fdivsqrt_iter_ctrl;
    localparam int CNTW = 6;

    logic clk = 1'b0;
    logic reset;
    logic Start, SqrtIn, SpecialCase, WZero, Stall, Flush;
    logic [1:0] Fmt;

    logic init0, iten0, j10, sqrtl0, busy0, done0;
    logic init1, iten1, j11, sqrtl1, busy1, done1;
    logic [CNTW-1:0] cnt0, cnt1;

    logic s_init, s_iten, s_j1, s_sqrtl, s_busy, s_done;
    logic [CNTW-1:0] s_cnt;
    bit use_q = 1'b0;

    fdivsqrt_iter_ctrl #(.Q_SUPPORTED(1'b0), .CNTW(CNTW)) dut (
        .clk(clk), .reset(reset), .Start(Start), .SqrtIn(SqrtIn), .Fmt(Fmt),
        .SpecialCase(SpecialCase), .WZero(WZero), .Stall(Stall), .Flush(Flush),
        .Init(init0), .IterEn(iten0), .j1(j10), .SqrtL(sqrtl0), .Busy(busy0),
        .Done(done0), .IterCnt(cnt0)
    );

    fdivsqrt_iter_ctrl #(.Q_SUPPORTED(1'b1), .CNTW(CNTW)) dut_q (
        .clk(clk), .reset(reset), .Start(Start), .SqrtIn(SqrtIn), .Fmt(Fmt),
        .SpecialCase(SpecialCase), .WZero(WZero), .Stall(Stall), .Flush(Flush),
        .Init(init1), .IterEn(iten1), .j1(j11), .SqrtL(sqrtl1), .Busy(busy1),
        .Done(done1), .IterCnt(cnt1)
    );

    always #5 clk = ~clk;

    always_comb begin
        if (use_q) {s_init, s_iten, s_j1, s_sqrtl, s_busy, s_done, s_cnt} =
                   {init1, iten1, j11, sqrtl1, busy1, done1, cnt1};
        else       {s_init, s_iten, s_j1, s_sqrtl, s_busy, s_done, s_cnt} =
                   {init0, iten0, j10, sqrtl0, busy0, done0, cnt0};
    end

    typedef struct {
        logic       sqrt;
        logic [1:0] fmt;
        logic       special;
        bit         use_q;
        int         done_at;
        int         iters;
        int         j1s;
        int         first_cnt;
    } vec_t;

    vec_t tbl[$];
    vec_t exp_q[$];
    int n_vec = 0;
    int n_fail = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic drain();
        int k;
        for (k = 0; k < 100; k++) begin
            smp();
            if (!busy0 && !done0 && !busy1 && !done1) break;
            next_cyc();
        end
        chk("drain_timeout", (k < 100) ? 1 : 0, 1);
        next_cyc();
    endtask

    task automatic run_op(input vec_t v);
        vec_t e;
        int iters = 0, j1s = 0, j1_late = 0, done_at = -1, first_cnt = -1;
        logic sq = 1'b0;
        use_q = v.use_q;
        Start = 1'b1; SqrtIn = v.sqrt; Fmt = v.fmt; SpecialCase = v.special;
        exp_q.push_back(v);
        smp();
        chk("accept_init", s_init, 1);
        for (int cyc = 1; cyc <= 80; cyc++) begin
            next_cyc();
            Start = 1'b0; SpecialCase = 1'b0; SqrtIn = ~v.sqrt; Fmt = 2'b10;
            smp();
            if (cyc == 1) first_cnt = int'(s_cnt);
            if (s_iten) iters++;
            if (s_j1) begin
                j1s++;
                if (cyc != 1) j1_late++;
            end
            if (s_done) begin
                done_at = cyc;
                sq = s_sqrtl;
                break;
            end
        end
        e = exp_q.pop_front();
        chk("done_cycle", done_at, e.done_at);
        chk("iter_cycles", iters, e.iters);
        chk("j1_count", j1s, e.j1s);
        chk("j1_late", j1_late, 0);
        chk("first_cnt", first_cnt, e.first_cnt);
        chk("sqrtl", sq, e.sqrt);
        next_cyc();
        smp();
        chk("back_idle", s_done | s_busy, 0);
        drain();
    endtask

    initial begin
        int seen;
        reset = 1'b1; Start = 1'b1; SqrtIn = 1'b0; Fmt = 2'b01;
        SpecialCase = 1'b0; WZero = 1'b0; Stall = 1'b0; Flush = 1'b0;

        //       sqrt fmt    sp    q    done iters j1 cnt1
        tbl.push_back('{1'b0, 2'b01, 1'b0, 1'b0, 29, 28, 0, 27});
        tbl.push_back('{1'b1, 2'b00, 1'b0, 1'b0, 15, 14, 1, 13});
        tbl.push_back('{1'b0, 2'b10, 1'b0, 1'b0,  8,  7, 0,  6});
        tbl.push_back('{1'b1, 2'b10, 1'b0, 1'b0,  8,  7, 1,  6});
        tbl.push_back('{1'b0, 2'b01, 1'b1, 1'b0,  1,  0, 0,  0});
        tbl.push_back('{1'b1, 2'b01, 1'b1, 1'b0,  1,  0, 0,  0});
        tbl.push_back('{1'b0, 2'b11, 1'b0, 1'b0, 29, 28, 0, 27});
        tbl.push_back('{1'b1, 2'b11, 1'b0, 1'b1, 59, 58, 1, 57});
        tbl.push_back('{1'b0, 2'b11, 1'b0, 1'b1, 59, 58, 0, 57});
        tbl.push_back('{1'b1, 2'b01, 1'b0, 1'b1, 29, 28, 1, 27});

        // reset state, with Start held high during reset
        smp();
        chk("reset_outs", {init0, iten0, j10, sqrtl0, busy0, done0, cnt0}, 0);
        next_cyc();
        Start = 1'b0;
        reset = 1'b0;
        smp();
        chk("post_reset_outs", {init0, iten0, j10, sqrtl0, busy0, done0, cnt0}, 0);
        next_cyc();

        foreach (tbl[i]) run_op(tbl[i]);
        use_q = 1'b0;

        // special case, a Start in DONE ignored, next accept, then flush at op cycle 10
        Start = 1'b1; SqrtIn = 1'b0; Fmt = 2'b01; SpecialCase = 1'b1;
        smp(); chk("sp_init", init0, 1);
        next_cyc(); SpecialCase = 1'b0;
        smp(); chk("sp_done_c1", done0, 1); chk("sp_init_c1", init0, 0);
        next_cyc();
        smp(); chk("reaccept_init_c2", init0, 1); chk("reaccept_done_c2", done0, 0);
        next_cyc(); Start = 1'b0;
        smp(); chk("reaccept_busy", busy0, 1); chk("reaccept_cnt", cnt0, 27);
        for (int c = 2; c <= 10; c++) next_cyc();
        Flush = 1'b1;
        smp(); chk("flush_cycle_busy", busy0, 1);
        next_cyc(); Flush = 1'b0;
        smp();
        chk("flush_idle", busy0 | done0, 0);
        chk("flush_cnt", cnt0, 0);
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            next_cyc(); smp();
            if (done0 || busy0) seen++;
        end
        chk("flush_no_done", seen, 0);

        // Start together with Flush in IDLE
        next_cyc();
        Start = 1'b1; Flush = 1'b1; Fmt = 2'b10;
        smp(); chk("start_flush_init", init0, 0);
        next_cyc(); Start = 1'b0; Flush = 1'b0;
        smp(); chk("start_flush_noacc", busy0 | done0, 0);

        // half divide: early exit at cycle 3, stall keeps Done through cycle 6
        next_cyc();
        Start = 1'b1; SqrtIn = 1'b0; Fmt = 2'b10;
        next_cyc(); Start = 1'b0;
        next_cyc();
        next_cyc(); WZero = 1'b1;
        smp(); chk("wz_iten_c3", iten0, 1); chk("wz_done_c3", done0, 0);
        next_cyc(); WZero = 1'b0; Stall = 1'b1;
        smp(); chk("wz_done_c4", done0, 1); chk("wz_iten_c4", iten0, 0);
        next_cyc();
        smp(); chk("stall_done_c5", done0, 1);
        next_cyc(); Stall = 1'b0;
        smp(); chk("stall_done_c6", done0, 1);
        next_cyc();
        smp(); chk("stall_idle_c7", done0 | busy0, 0);
        drain();

        // WZero during the j1 step must not terminate
        Start = 1'b1; SqrtIn = 1'b1; Fmt = 2'b10;
        next_cyc(); Start = 1'b0; WZero = 1'b1;
        smp(); chk("wz_j1_j1", j10, 1);
        next_cyc(); WZero = 1'b0;
        smp(); chk("wz_j1_still_busy", busy0, 1); chk("wz_j1_no_done", done0, 0);
        drain();

        // async reset mid-operation
        Start = 1'b1; SqrtIn = 1'b1; Fmt = 2'b01;
        for (int c = 1; c <= 5; c++) begin
            next_cyc(); Start = 1'b0;
        end
        smp(); chk("pre_reset_busy", busy0, 1);
        #2 reset = 1'b1;
        #1;
        chk("async_reset_outs0", {init0, iten0, j10, sqrtl0, busy0, done0, cnt0}, 0);
        chk("async_reset_outs1", {init1, iten1, j11, sqrtl1, busy1, done1, cnt1}, 0);
        next_cyc(); reset = 1'b0;
        smp(); chk("after_reset_idle", busy0 | done0 | busy1 | done1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
